// File: rtl/mlp_pkg.sv
// -----------------------------------------------------------------------------
// mlp_pkg
// Shared constants and types for the MLP weight-fetch controller.
//   DW         : weight word width
//   DEPTH      : total words across the three weight banks
//   BANK_WORDS : words per bank (DEPTH = NUM_BANKS * BANK_WORDS)
//   RD_LAT     : cycles from a read request to its data on data_in
//   FIFO_DEPTH : output buffer entries (power of two)
//   AW         : flat word address width
//   state_e    : controller FSM state encoding
// -----------------------------------------------------------------------------
package mlp_pkg;

  localparam int DW         = 27;
  localparam int BANK_WORDS = 25;
  localparam int NUM_BANKS  = 3;
  localparam int DEPTH      = NUM_BANKS * BANK_WORDS;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int AW         = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mlp_fetch_fifo.sv
// -----------------------------------------------------------------------------
// mlp_fetch_fifo
// First-word fall-through buffer between the weight memory return path and
// the consumer. The head entry is visible on data_o whenever valid_o is high.
//   clk, rst : clock, synchronous active-high reset (clears pointers/count)
//   push_i   : write data_i this cycle
//   data_i   : word to write
//   pop_i    : remove the head entry this cycle (ignored when empty)
//   data_o   : head entry
//   valid_o  : buffer is non-empty
//   count_o  : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module mlp_fetch_fifo #(
  parameter int DW    = mlp_pkg::DW,
  parameter int DEPTH = mlp_pkg::FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DW-1:0]            data_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only observed after it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // The upstream credit rule must make a dropped push impossible.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push_i && full && !do_pop));
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/mlp_weight_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// mlp_weight_fetch_ctrl
// Streams num_words consecutive weight words (flat address 0..num_words-1)
// from a fixed-latency banked memory into an output stream, in address order.
//   clk, rst  : clock, synchronous active-high reset
//   start     : one-cycle run request, num_words sampled with it
//   num_words : run length, legal 1..DEPTH; anything else pulses err
//   rd_en     : read issued this cycle at rd_addr (rd_addr is 0 otherwise)
//   data_in   : read data, valid exactly RD_LAT cycles after its rd_en
//   out_valid / out_ready / out_data / out_last : output stream
//   busy      : run in progress
//   done      : one-cycle pulse after the last word is accepted
//   err       : one-cycle pulse after a rejected start
//   state_o   : FSM state, for observation
//
// Output handshake: a word transfers on every cycle where out_valid and
// out_ready are both high. Once out_valid is raised it stays high with
// out_data and out_last unchanged until that transfer happens.
// -----------------------------------------------------------------------------
module mlp_weight_fetch_ctrl #(
  parameter int DW         = mlp_pkg::DW,
  parameter int DEPTH      = mlp_pkg::DEPTH,
  parameter int RD_LAT     = mlp_pkg::RD_LAT,
  parameter int FIFO_DEPTH = mlp_pkg::FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [6:0]      num_words,
  output logic            rd_en,
  output logic [6:0]      rd_addr,
  input  logic [DW-1:0]   data_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  output logic            busy,
  output logic            done,
  output logic            err,
  output mlp_pkg::state_e state_o
);

  import mlp_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

  state_e            state_q, state_d;
  logic [AW-1:0]     num_q, num_d;
  logic [AW-1:0]     issued_q, issued_d;
  logic [AW-1:0]     popped_q, popped_d;
  logic [RD_LAT-1:0] vpipe_q, vpipe_d;
  logic              err_q, err_d;

  logic [CW-1:0]     fifo_count;
  logic [DW-1:0]     fifo_data;
  logic              fifo_valid;
  logic              push;
  logic              pop;
  logic [7:0]        inflight;
  logic [7:0]        credit_used;
  logic              start_ok;
  logic              rd_en_int;
  logic              last_head;

  // Words already owed to the buffer: reads still in the return pipe plus
  // words sitting in it. Keeping this below FIFO_DEPTH means every returning
  // word has a slot, so the memory side never needs back-pressure.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + 8'(vpipe_q[i]);
  end

  assign credit_used = 8'(fifo_count) + inflight;
  assign start_ok    = (num_words != '0) && (num_words <= DEPTH_W);
  assign rd_en_int   = (state_q == ST_FETCH) && (credit_used < 8'(FIFO_DEPTH)) &&
                       (issued_q < num_q);
  assign push        = vpipe_q[RD_LAT-1];
  assign pop         = out_valid && out_ready;
  assign last_head   = (popped_q == num_q - 1'b1);

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    issued_d = issued_q;
    popped_d = popped_q;
    err_d    = 1'b0;

    // Valid pipe tracks each read until its data appears on data_in.
    vpipe_d[0] = rd_en_int;
    for (int i = 1; i < RD_LAT; i++) vpipe_d[i] = vpipe_q[i-1];

    if (rd_en_int) issued_d = issued_q + 1'b1;
    if (pop)       popped_d = popped_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (start_ok) begin
            state_d  = ST_FETCH;
            num_d    = num_words;
            issued_d = '0;
            popped_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        if (rd_en_int && (issued_q == num_q - 1'b1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && last_head) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      num_q    <= '0;
      issued_q <= '0;
      popped_q <= '0;
      vpipe_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      issued_q <= issued_d;
      popped_q <= popped_d;
      vpipe_q  <= vpipe_d;
      err_q    <= err_d;
    end
  end

  mlp_fetch_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (data_in),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  // Outputs are forced low while rst is high, so a mid-run reset silences the
  // interface in the reset cycle itself rather than one cycle later.
  assign rd_en     = rd_en_int && !rst;
  assign rd_addr   = rd_en ? issued_q : '0;
  assign out_valid = fifo_valid && !rst;
  assign out_data  = out_valid ? fifo_data : '0;
  assign out_last  = out_valid && last_head;
  assign busy      = !rst && ((state_q == ST_FETCH) || (state_q == ST_DRAIN));
  assign done      = !rst && (state_q == ST_DONE);
  assign err       = !rst && err_q;
  assign state_o   = state_q;

endmodule
